hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have one clock `clk`; `reset` SHALL be synchronous and active-high.
REQ-002 `clk`  in  1  pipeline clock, all state updates on rising edge.
REQ-003 `reset`  in  1  synchronous active-high reset.
REQ-004 `rs_D`, `rt_D`  in  5 each  source register numbers of the instruction in D.
REQ-005 `Tuse_Rs_D`, `Tuse_Rt_D`  in  2 each  cycles until D needs rs/rt; 2'b11 = operand unused.
REQ-006 `A3_E`, `Tnew_E`, `GRF_WE_E`  in  5/2/1  destination, cycles-to-result and write-enable of the E instruction.
REQ-007 `A3_M`, `Tnew_M`, `GRF_WE_M`  in  5/2/1  the same fields for the M instruction.
REQ-008 `MD_start_E`, `MD_isdiv_E`  in  1/1  E holds mult/multu (isdiv=0) or div/divu (isdiv=1).
REQ-009 `MD_use_D`  in  1  D instruction reads or writes HI/LO or starts a new mult/div.
REQ-010 `Exc_M`, `eret_M`  in  1/1  exception taken / eret committing in M.
REQ-011 `stall`  out  1  drives F_D stall and PC hold.
REQ-012 `clr_F_D`, `clr_D_E`  out  1/1  clears for the F/D and D/E registers.
REQ-013 `md_busy`  out  1  multiply/divide unit is occupied.

Function
REQ-014 GPR hazard on rs SHALL be `rs_D != 0` && `Tuse_Rs_D != 3` && ((`GRF_WE_E` && `A3_E == rs_D` && `Tnew_E > Tuse_Rs_D`) || (`GRF_WE_M` && `A3_M == rs_D` && `Tnew_M > Tuse_Rs_D`)).
REQ-015 The rt GPR hazard SHALL use the same rule with `rt_D` and `Tuse_Rt_D`.
REQ-016 The MD hazard SHALL be `MD_use_D` && (`md_busy` || `MD_start_E`).
REQ-017 `stall` SHALL be the OR of the rs, rt and MD hazards, SHALL be combinational, and SHALL be gated low when `flush` is high.
REQ-018 `flush` SHALL be `Exc_M` || `eret_M`.
REQ-019 `clr_D_E` SHALL be `stall` || `flush`, so a stall inserts exactly one bubble per stalled cycle.
REQ-020 `clr_F_D` SHALL be `flush`.
REQ-021 The MD counter is 4 bits; 0 = idle. When `MD_start_E` && !`flush` && count==0, it SHALL load MULT_LAT=5 if `MD_isdiv_E`=0, else DIV_LAT=10.
REQ-022 When count != 0, it SHALL decrement by 1 each cycle and SHALL NOT wrap below 0.
REQ-023 `md_busy` SHALL be (count != 0) and SHALL be registered.
REQ-024 `MD_start_E` while count != 0 SHALL be ignored; the REQ-016 stall makes this unreachable in legal operation.
REQ-025 `MD_start_E` together with `flush` SHALL NOT load the counter, because the E instruction is squashed.
REQ-026 A counter already running when `flush` occurs SHALL continue to 0, because the older operation is committed.
REQ-027 Simultaneous E-stage and M-stage matches on the same register SHALL stall if either term is true.

Reset
REQ-028 On `reset` the MD counter SHALL be 0. `md_busy`=0 in the next cycle.
REQ-029 Reset mid-count SHALL abort the operation.
REQ-030 During reset, the combinational outputs SHALL follow REQ-014..020 on the current inputs; the pipeline registers clear themselves on reset.

Configuration
REQ-031 Macro `HAZ_MDU_EN` defined: the MD counter, `md_busy` and the MD hazard SHALL be present.
REQ-032 Macro `HAZ_MDU_EN` undefined: `md_busy` SHALL be tied to 0, the MD hazard SHALL be 0, and no counter flops SHALL exist.

Structure
REQ-033 The shared package `hazard_pkg` SHALL hold MULT_LAT, DIV_LAT, TUSE_NONE=2'b11 and the counter width.
REQ-034 The MD counter SHALL be a sub-module `md_busy_cnt` (ports: clk, reset, start, isdiv, kill, busy).

Verification
REQ-035 `rs_D`=5, `Tuse_Rs_D`=0, E: `A3_E`=5, `GRF_WE_E`=1, `Tnew_E`=2 -> `stall`=1, `clr_D_E`=1; with `Tnew_E`=0 -> `stall`=0.
REQ-036 `rs_D`=0 with `A3_E`=0, `GRF_WE_E`=1, `Tnew_E`=2 -> `stall`=0. `Tuse_Rt_D`=3 with `A3_M`=`rt_D`=7, `Tnew_M`=1 -> `stall`=0.
REQ-037 MD timing:
- `MD_start_E`=1, `MD_isdiv_E`=1 for one cycle -> `md_busy`=1 for exactly 10 cycles.
- `MD_use_D`=1 during that window -> `stall`=1 each of those cycles, 0 after.
- Same test with mult -> 5 cycles.
REQ-038 `Exc_M`=1 in the same cycle as a GPR hazard and `MD_start_E`=1 -> `stall`=0, `clr_F_D`=1, `clr_D_E`=1, `md_busy` stays 0.
REQ-039 `reset` asserted at count=4 -> next cycle `md_busy`=0. A fresh `MD_start_E` then loads 5 or 10 normally.
REQ-040 Build without `HAZ_MDU_EN`, repeat REQ-037 stimulus -> `md_busy`=0 and `stall`=0 throughout.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Holds the mult/div latencies, the "operand unused" Tuse code and the busy-counter width.
package hazard_pkg;

    localparam int              CNT_W     = 4;
    localparam logic [CNT_W-1:0] MULT_LAT = 4'd5;
    localparam logic [CNT_W-1:0] DIV_LAT  = 4'd10;
    localparam logic [1:0]      TUSE_NONE = 2'b11;

    // Destination-side view of an in-flight instruction (E or M stage).
    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       we;
    } producer_t;

    // True when a source register read in D cannot yet be satisfied by forwarding.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input producer_t  e,
        input producer_t  m
    );
        logic e_hit;
        logic m_hit;
        e_hit = e.we && (e.a3 == src) && (e.tnew > tuse);
        m_hit = m.we && (m.a3 == src) && (m.tnew > tuse);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Multiply/divide occupancy counter: loads the unit latency on an accepted start
// and counts down to idle; busy is a registered copy of (count != 0).
module md_busy_cnt
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic isdiv,
    input  logic kill,
    output logic busy
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        // NOTE: default first so every path assigns count_nxt and no latch is inferred.
        count_nxt = count;
        if (count != '0) begin
            // A running operation is already committed; start and kill are ignored.
            count_nxt = count - CNT_W'(1);
        end else if (start && !kill) begin
            count_nxt = isdiv ? DIV_LAT : MULT_LAT;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= count_nxt;
            busy  <= (count_nxt != '0);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: GPR Tuse/Tnew stall detection, exception/eret flush
// and optional mult/div busy tracking (enabled by the HAZ_MDU_EN macro).
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] Tuse_Rs_D,
    input  logic [1:0] Tuse_Rt_D,
    input  logic [4:0] A3_E,
    input  logic [1:0] Tnew_E,
    input  logic       GRF_WE_E,
    input  logic [4:0] A3_M,
    input  logic [1:0] Tnew_M,
    input  logic       GRF_WE_M,
    input  logic       MD_start_E,
    input  logic       MD_isdiv_E,
    input  logic       MD_use_D,
    input  logic       Exc_M,
    input  logic       eret_M,
    output logic       stall,
    output logic       clr_F_D,
    output logic       clr_D_E,
    output logic       md_busy
);

    producer_t prod_e;
    producer_t prod_m;
    logic      rs_hazard;
    logic      rt_hazard;
    logic      md_hazard;
    logic      flush;

    assign prod_e = '{a3: A3_E, tnew: Tnew_E, we: GRF_WE_E};
    assign prod_m = '{a3: A3_M, tnew: Tnew_M, we: GRF_WE_M};

    assign rs_hazard = src_hazard(rs_D, Tuse_Rs_D, prod_e, prod_m);
    assign rt_hazard = src_hazard(rt_D, Tuse_Rt_D, prod_e, prod_m);

`ifdef HAZ_MDU_EN
    md_busy_cnt u_md_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .start (MD_start_E),
        .isdiv (MD_isdiv_E),
        .kill  (flush),
        .busy  (md_busy)
    );

    // A start in E counts as busy already, so a following HI/LO user waits.
    assign md_hazard = MD_use_D && (md_busy || MD_start_E);
`else
    logic unused_md;

    assign unused_md = ^{clk, reset, MD_start_E, MD_isdiv_E, MD_use_D};
    assign md_busy   = 1'b0;
    assign md_hazard = 1'b0;
`endif

    // A squashing flush overrides any stall so the redirect is never held off.
    assign flush   = Exc_M || eret_M;
    assign stall   = (rs_hazard || rt_hazard || md_hazard) && !flush;
    assign clr_F_D = flush;
    assign clr_D_E = stall || flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares. Expectations follow HAZ_MDU_EN.
module tb_hazard_ctrl;

`ifdef HAZ_MDU_EN
    localparam bit MDU = 1'b1;
`else
    localparam bit MDU = 1'b0;
`endif

    typedef struct packed {
        logic stall;
        logic clr_f_d;
        logic clr_d_e;
        logic md_busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, A3_E, A3_M;
    logic [1:0] Tuse_Rs_D, Tuse_Rt_D, Tnew_E, Tnew_M;
    logic       GRF_WE_E, GRF_WE_M;
    logic       MD_start_E, MD_isdiv_E, MD_use_D, Exc_M, eret_M;
    logic       stall, clr_F_D, clr_D_E, md_busy;

    exp_t  exp_q[$];
    string name_q[$];
    logic  vec_valid = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .Tuse_Rs_D  (Tuse_Rs_D),
        .Tuse_Rt_D  (Tuse_Rt_D),
        .A3_E       (A3_E),
        .Tnew_E     (Tnew_E),
        .GRF_WE_E   (GRF_WE_E),
        .A3_M       (A3_M),
        .Tnew_M     (Tnew_M),
        .GRF_WE_M   (GRF_WE_M),
        .MD_start_E (MD_start_E),
        .MD_isdiv_E (MD_isdiv_E),
        .MD_use_D   (MD_use_D),
        .Exc_M      (Exc_M),
        .eret_M     (eret_M),
        .stall      (stall),
        .clr_F_D    (clr_F_D),
        .clr_D_E    (clr_D_E),
        .md_busy    (md_busy)
    );

    // Monitor: one comparison per presented vector, sampled mid-cycle.
    always @(negedge clk) begin
        if (vec_valid) begin
            exp_t  e;
            exp_t  got;
            string nm;
            got = '{stall: stall, clr_f_d: clr_F_D, clr_d_e: clr_D_E, md_busy: md_busy};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_underflow: got output with no expected entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL %s: got stall=%b clr_F_D=%b clr_D_E=%b md_busy=%b, want stall=%b clr_F_D=%b clr_D_E=%b md_busy=%b",
                             nm, got.stall, got.clr_f_d, got.clr_d_e, got.md_busy,
                             e.stall, e.clr_f_d, e.clr_d_e, e.md_busy);
                end
            end
        end
    end

    task automatic clear_inputs();
        rs_D = 5'd0; rt_D = 5'd0; Tuse_Rs_D = 2'd0; Tuse_Rt_D = 2'd0;
        A3_E = 5'd0; Tnew_E = 2'd0; GRF_WE_E = 1'b0;
        A3_M = 5'd0; Tnew_M = 2'd0; GRF_WE_M = 1'b0;
        MD_start_E = 1'b0; MD_isdiv_E = 1'b0; MD_use_D = 1'b0;
        Exc_M = 1'b0; eret_M = 1'b0;
    endtask

    // Inputs are already driven; queue the expectation and spend one cycle.
    task automatic step(input string nm, input logic s, input logic cfd, input logic cde, input logic b);
        exp_q.push_back('{stall: s, clr_f_d: cfd, clr_d_e: cde, md_busy: b});
        name_q.push_back(nm);
        vec_valid = 1'b1;
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
    endtask

    // One-cycle start, then lat busy cycles with MD_use_D held, then one idle cycle.
    task automatic md_window(input string nm, input bit isdiv, input int lat, input bit use_at_start);
        clear_inputs();
        MD_start_E = 1'b1; MD_isdiv_E = isdiv; MD_use_D = use_at_start;
        step({nm, "_start"}, MDU && use_at_start, 1'b0, MDU && use_at_start, 1'b0);
        for (int i = 1; i <= lat; i++) begin
            clear_inputs();
            MD_use_D = 1'b1;
            if (isdiv && i == 3) begin
                MD_start_E = 1'b1;  // restart while busy must be ignored
            end
            if (!isdiv && i == 2) begin
                Exc_M = 1'b1;       // flush does not abort a committed op
                step($sformatf("%s_flush%0d", nm, i), 1'b0, 1'b1, 1'b1, MDU);
            end else begin
                step($sformatf("%s_busy%0d", nm, i), MDU, 1'b0, MDU, MDU);
            end
        end
        clear_inputs();
        MD_use_D = 1'b1;
        step({nm, "_done"}, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        rs_D = 5'd5; A3_E = 5'd5; GRF_WE_E = 1'b1; Tnew_E = 2'd2;
        step("reset_comb_stall", 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;

        clear_inputs();
        rs_D = 5'd5; A3_E = 5'd5; GRF_WE_E = 1'b1; Tnew_E = 2'd2;
        step("rs_e_stall", 1'b1, 1'b0, 1'b1, 1'b0);
        Tnew_E = 2'd0;
        step("rs_e_tnew0", 1'b0, 1'b0, 1'b0, 1'b0);
        Tnew_E = 2'd1; Tuse_Rs_D = 2'd1;
        step("rs_tnew_eq_tuse", 1'b0, 1'b0, 1'b0, 1'b0);
        Tnew_E = 2'd2;
        step("rs_tnew_gt_tuse", 1'b1, 1'b0, 1'b1, 1'b0);

        clear_inputs();
        A3_E = 5'd0; GRF_WE_E = 1'b1; Tnew_E = 2'd2;
        step("rs_zero_reg", 1'b0, 1'b0, 1'b0, 1'b0);

        clear_inputs();
        rt_D = 5'd7; A3_M = 5'd7; GRF_WE_M = 1'b1; Tnew_M = 2'd1; Tuse_Rt_D = 2'b11;
        step("rt_unused", 1'b0, 1'b0, 1'b0, 1'b0);
        Tuse_Rt_D = 2'd0;
        step("rt_m_stall", 1'b1, 1'b0, 1'b1, 1'b0);
        GRF_WE_M = 1'b0;
        step("rt_m_no_we", 1'b0, 1'b0, 1'b0, 1'b0);

        clear_inputs();
        rs_D = 5'd9; Tuse_Rs_D = 2'd1;
        A3_E = 5'd9; GRF_WE_E = 1'b1; Tnew_E = 2'd0;
        A3_M = 5'd9; GRF_WE_M = 1'b1; Tnew_M = 2'd2;
        step("rs_e_and_m_match", 1'b1, 1'b0, 1'b1, 1'b0);
        A3_M = 5'd8;
        step("rs_no_match", 1'b0, 1'b0, 1'b0, 1'b0);

        clear_inputs();
        rs_D = 5'd5; A3_E = 5'd5; GRF_WE_E = 1'b1; Tnew_E = 2'd2;
        MD_start_E = 1'b1; MD_isdiv_E = 1'b1; MD_use_D = 1'b1; Exc_M = 1'b1;
        step("exc_flush", 1'b0, 1'b1, 1'b1, 1'b0);
        clear_inputs();
        step("exc_no_load", 1'b0, 1'b0, 1'b0, 1'b0);
        eret_M = 1'b1;
        step("eret_flush", 1'b0, 1'b1, 1'b1, 1'b0);

        md_window("div", 1'b1, 10, 1'b0);
        md_window("mult", 1'b0, 5, 1'b1);

        clear_inputs();
        MD_start_E = 1'b1; MD_isdiv_E = 1'b1;
        step("rst_div_start", 1'b0, 1'b0, 1'b0, 1'b0);
        clear_inputs();
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) reset = 1'b1;   // count is 4 in this cycle
            step($sformatf("rst_div_busy%0d", i), 1'b0, 1'b0, 1'b0, MDU);
        end
        reset = 1'b0;
        step("rst_aborted", 1'b0, 1'b0, 1'b0, 1'b0);
        md_window("post_rst_mult", 1'b0, 5, 1'b0);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
